universal_shift_register: RTL and testbench

Parametrised universal shift register: parallel load, logical shift and rotate in both directions, synchronous clear, and an optional self-timed burst mode that serialises the stored word MSB-first over WIDTH cycles. It is the general-purpose successor to the fixed 4-bit parallel-in/parallel-out register. It sits between parallel datapaths and serial links, replacing dedicated SIPO, PISO and PIPO instances.

---
 rtl/usr_pkg.sv | 22 ++
 rtl/usr_shift_core.sv | 36 +++
 rtl/universal_shift_register.sv | 135 +++++++++++++
 tb/tb_universal_shift_register.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// usr_pkg: shared types for the universal shift register.
//   op_e    - 3-bit operation select driven on the op port
//   state_e - burst sequencer state (used only when USR_BURST_EN is defined)
package usr_pkg;

   typedef enum logic [2:0] {
      OP_HOLD  = 3'b000,
      OP_LOAD  = 3'b001,
      OP_SHL   = 3'b010,
      OP_SHR   = 3'b011,
      OP_ROL   = 3'b100,
      OP_ROR   = 3'b101,
      OP_CLEAR = 3'b110,
      OP_BURST = 3'b111
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/usr_shift_core.sv
// usr_shift_core: combinational next-word mux for the universal shift register.
// Ports:
//   op          in  op_e   effective operation (already qualified by en/burst)
//   cur         in  WIDTH  current register word
//   serial_in_l in  1      bit entering bit 0 on left shift
//   serial_in_r in  1      bit entering bit WIDTH-1 on right shift
//   nxt         out WIDTH  next register word
// OP_BURST never reaches the mux as a shift; the top maps it, so here it holds.
module usr_shift_core
   import usr_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] cur,
   input  logic             serial_in_l,
   input  logic             serial_in_r,
   output logic [WIDTH-1:0] nxt
);

   always_comb begin
      nxt = cur;
      case (op)
         OP_HOLD:  nxt = cur;
         OP_LOAD:  nxt = cur;
         OP_SHL:   nxt = {cur[WIDTH-2:0], serial_in_l};
         OP_SHR:   nxt = {serial_in_r, cur[WIDTH-1:1]};
         OP_ROL:   nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
         OP_ROR:   nxt = {cur[0], cur[WIDTH-1:1]};
         OP_CLEAR: nxt = '0;
         OP_BURST: nxt = cur;
         default:  nxt = cur;
      endcase
   end

endmodule

// File: rtl/universal_shift_register.sv
// universal_shift_register: parallel load, logical shift / rotate both ways,
// synchronous clear and an optional self-timed MSB-first burst.
// Optional feature macro: USR_BURST_EN (burst FSM, counter, busy, done).
// Without it, op 111 holds and busy/done are constant 0.
// Ports:
//   clk          in  1      rising-edge clock
//   reset        in  1      asynchronous active-low reset
//   en           in  1      operation enable (ignored while busy, except CLEAR)
//   op           in  3      operation select (usr_pkg::op_e encoding)
//   parallel_in  in  WIDTH  load data
//   serial_in_l  in  1      bit entering bit 0 on left shift / burst
//   serial_in_r  in  1      bit entering bit WIDTH-1 on right shift
//   parallel_out out WIDTH  register contents
//   serial_out_l out 1      parallel_out[WIDTH-1]
//   serial_out_r out 1      parallel_out[0]
//   busy         out 1      burst in progress
//   done         out 1      one-cycle pulse when a burst completes
//
// Burst FSM states:
//   state   | meaning
//   ST_IDLE | normal ops accepted when en=1; BURST shifts once and arms cnt
//   ST_BUSY | shifts left every edge; CLEAR with en=1 aborts; cnt==1 finishes
module universal_shift_register
   import usr_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             serial_in_l,
   input  logic             serial_in_r,
   output logic [WIDTH-1:0] parallel_out,
   output logic             serial_out_l,
   output logic             serial_out_r,
   output logic             busy,
   output logic             done
);

   op_e              op_i;
   op_e              core_op;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] shift_nxt;
   logic [WIDTH-1:0] data_d;

   assign op_i = op_e'(op);

   usr_shift_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op          (core_op),
      .cur         (data_q),
      .serial_in_l (serial_in_l),
      .serial_in_r (serial_in_r),
      .nxt         (shift_nxt)
   );

   // LOAD is resolved here so the core never needs parallel_in.
   assign data_d = (core_op == OP_LOAD) ? parallel_in : shift_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

`ifdef USR_BURST_EN
   localparam int CNT_W = $clog2(WIDTH);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;

   always_comb begin
      core_op = OP_HOLD;
      if (state_q == ST_BUSY) begin
         core_op = (en && op_i == OP_CLEAR) ? OP_CLEAR : OP_SHL;
      end else if (en) begin
         // The accepting edge already performs the first of WIDTH shifts.
         core_op = (op_i == OP_BURST) ? OP_SHL : op_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (en && op_i == OP_BURST) begin
                  state_q <= ST_BUSY;
                  cnt_q   <= CNT_W'(WIDTH - 1);
               end
            end
            ST_BUSY: begin
               if (en && op_i == OP_CLEAR) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_W'(1)) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign busy = (state_q == ST_BUSY);
   assign done = done_q;
`else
   // BURST passes through to the core, which treats it as HOLD.
   assign core_op = en ? op_i : OP_HOLD;
   assign busy    = 1'b0;
   assign done    = 1'b0;
`endif

   assign parallel_out = data_q;
   assign serial_out_l = data_q[WIDTH-1];
   assign serial_out_r = data_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic         en;
   logic [2:0]   op;
   logic [W-1:0] parallel_in;
   logic         serial_in_l;
   logic         serial_in_r;
   logic [W-1:0] parallel_out;
   logic         serial_out_l;
   logic         serial_out_r;
   logic         busy;
   logic         done;

   localparam logic [2:0] HOLD  = 3'b000;
   localparam logic [2:0] LOAD  = 3'b001;
   localparam logic [2:0] SHL   = 3'b010;
   localparam logic [2:0] SHR   = 3'b011;
   localparam logic [2:0] ROL   = 3'b100;
   localparam logic [2:0] ROR   = 3'b101;
   localparam logic [2:0] CLEAR = 3'b110;
   localparam logic [2:0] BURST = 3'b111;

   typedef struct {
      string        tag;
      logic [W-1:0] pout;
      logic         busy;
      logic         done;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   universal_shift_register #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .op           (op),
      .parallel_in  (parallel_in),
      .serial_in_l  (serial_in_l),
      .serial_in_r  (serial_in_r),
      .parallel_out (parallel_out),
      .serial_out_l (serial_out_l),
      .serial_out_r (serial_out_r),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog tests=%0d", n_tests);
      $fatal(1, "watchdog expired");
   end

   task automatic drive(input logic e, input logic [2:0] o, input logic [W-1:0] pin,
                        input logic sl, input logic sr);
      en          = e;
      op          = o;
      parallel_in = pin;
      serial_in_l = sl;
      serial_in_r = sr;
   endtask

   task automatic push(input string tag, input logic [W-1:0] p, input logic b, input logic d);
      exp_t e;
      e.tag  = tag;
      e.pout = p;
      e.busy = b;
      e.done = d;
      sb.push_back(e);
   endtask

   task automatic compare_front();
      exp_t e;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_empty got none want entry");
         return;
      end
      e = sb.pop_front();
      n_tests++;
      assert (parallel_out === e.pout) else begin
         n_fail++;
         $error("FAIL %s parallel_out got %b want %b", e.tag, parallel_out, e.pout);
      end
      n_tests++;
      assert (serial_out_l === e.pout[W-1] && serial_out_r === e.pout[0]) else begin
         n_fail++;
         $error("FAIL %s serial_out l/r got %b%b want %b%b", e.tag, serial_out_l,
                serial_out_r, e.pout[W-1], e.pout[0]);
      end
      n_tests++;
      assert (busy === e.busy) else begin
         n_fail++;
         $error("FAIL %s busy got %b want %b", e.tag, busy, e.busy);
      end
      n_tests++;
      assert (done === e.done) else begin
         n_fail++;
         $error("FAIL %s done got %b want %b", e.tag, done, e.done);
      end
   endtask

   // Expectation for the word after the next rising edge.
   task automatic tick(input string tag, input logic [W-1:0] p, input logic b, input logic d);
      push(tag, p, b, d);
      @(posedge clk);
      #1;
      compare_front();
   endtask

   // Asynchronous reset pulse started mid-cycle; checked before any edge.
   task automatic async_reset_check(input string tag);
      #2;
      reset = 1'b0;
      push(tag, '0, 1'b0, 1'b0);
      #1;
      compare_front();
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, HOLD, '0, 1'b0, 1'b0);
      #1;
      push("reset_init", '0, 1'b0, 1'b0);
      compare_front();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      drive(1'b1, LOAD, 4'b1011, 1'b0, 1'b0);
      tick("load_1011", 4'b1011, 1'b0, 1'b0);
      async_reset_check("reset_async");

      drive(1'b1, LOAD, 4'b1011, 1'b0, 1'b0);
      tick("reload", 4'b1011, 1'b0, 1'b0);
      drive(1'b0, LOAD, 4'b0110, 1'b0, 1'b0);
      tick("en0_hold", 4'b1011, 1'b0, 1'b0);
      drive(1'b0, CLEAR, 4'b0110, 1'b0, 1'b0);
      tick("en0_clear_hold", 4'b1011, 1'b0, 1'b0);

      drive(1'b1, SHL, '0, 1'b1, 1'b0);
      tick("shl_si1", 4'b0111, 1'b0, 1'b0);
      drive(1'b1, LOAD, 4'b1011, 1'b0, 1'b0);
      tick("load_a", 4'b1011, 1'b0, 1'b0);
      drive(1'b1, SHL, '0, 1'b0, 1'b1);
      tick("shl_si0", 4'b0110, 1'b0, 1'b0);
      drive(1'b1, LOAD, 4'b1011, 1'b0, 1'b0);
      tick("load_b", 4'b1011, 1'b0, 1'b0);
      drive(1'b1, SHR, '0, 1'b1, 1'b0);
      tick("shr_si0", 4'b0101, 1'b0, 1'b0);
      drive(1'b1, LOAD, 4'b1011, 1'b0, 1'b0);
      tick("load_c", 4'b1011, 1'b0, 1'b0);
      drive(1'b1, SHR, '0, 1'b0, 1'b1);
      tick("shr_si1", 4'b1101, 1'b0, 1'b0);
      drive(1'b1, LOAD, 4'b1011, 1'b0, 1'b0);
      tick("load_d", 4'b1011, 1'b0, 1'b0);
      drive(1'b1, ROL, '0, 1'b0, 1'b0);
      tick("rol", 4'b0111, 1'b0, 1'b0);
      drive(1'b1, LOAD, 4'b1011, 1'b0, 1'b0);
      tick("load_e", 4'b1011, 1'b0, 1'b0);
      drive(1'b1, ROR, '0, 1'b0, 1'b0);
      tick("ror", 4'b1101, 1'b0, 1'b0);
      drive(1'b1, LOAD, 4'b1011, 1'b0, 1'b0);
      tick("load_f", 4'b1011, 1'b0, 1'b0);
      drive(1'b1, CLEAR, 4'b1111, 1'b1, 1'b1);
      tick("clear", 4'b0000, 1'b0, 1'b0);

`ifdef USR_BURST_EN
      // Full burst of 1011: serial_out_l shows 1 before the accept edge,
      // then 0,1,1 after each shift.
      drive(1'b1, LOAD, 4'b1011, 1'b0, 1'b0);
      tick("burst_load", 4'b1011, 1'b0, 1'b0);
      drive(1'b1, BURST, '0, 1'b0, 1'b0);
      tick("burst_s1", 4'b0110, 1'b1, 1'b0);
      drive(1'b1, LOAD, 4'b1111, 1'b0, 1'b0);
      tick("burst_s2_load_ignored", 4'b1100, 1'b1, 1'b0);
      drive(1'b1, ROR, 4'b1111, 1'b0, 1'b1);
      tick("burst_s3", 4'b1000, 1'b1, 1'b0);
      drive(1'b1, LOAD, 4'b1001, 1'b0, 1'b0);
      tick("burst_done", 4'b0000, 1'b0, 1'b1);
      // Back-to-back: the LOAD driven during the done cycle is accepted.
      tick("after_done_load", 4'b1001, 1'b0, 1'b0);

      // Abort by reset after two shifts.
      drive(1'b1, LOAD, 4'b1011, 1'b0, 1'b0);
      tick("abr_load", 4'b1011, 1'b0, 1'b0);
      drive(1'b1, BURST, '0, 1'b0, 1'b0);
      tick("abr_s1", 4'b0110, 1'b1, 1'b0);
      drive(1'b0, HOLD, '0, 1'b0, 1'b0);
      tick("abr_s2", 4'b1100, 1'b1, 1'b0);
      async_reset_check("abr_reset");
      tick("abr_idle1", 4'b0000, 1'b0, 1'b0);
      tick("abr_idle2", 4'b0000, 1'b0, 1'b0);

      // Abort by CLEAR after two shifts.
      drive(1'b1, LOAD, 4'b1011, 1'b0, 1'b0);
      tick("abc_load", 4'b1011, 1'b0, 1'b0);
      drive(1'b1, BURST, '0, 1'b1, 1'b0);
      tick("abc_s1", 4'b0111, 1'b1, 1'b0);
      drive(1'b0, CLEAR, '0, 1'b1, 1'b0);
      tick("abc_s2_en0_clear", 4'b1111, 1'b1, 1'b0);
      drive(1'b1, CLEAR, '0, 1'b1, 1'b0);
      tick("abc_clear", 4'b0000, 1'b0, 1'b0);
      drive(1'b0, HOLD, '0, 1'b0, 1'b0);
      tick("abc_idle1", 4'b0000, 1'b0, 1'b0);
      tick("abc_idle2", 4'b0000, 1'b0, 1'b0);
`else
      drive(1'b1, LOAD, 4'b1011, 1'b0, 1'b0);
      tick("nb_load", 4'b1011, 1'b0, 1'b0);
      drive(1'b1, BURST, 4'b0000, 1'b1, 1'b1);
      tick("nb_op7_hold1", 4'b1011, 1'b0, 1'b0);
      tick("nb_op7_hold2", 4'b1011, 1'b0, 1'b0);
      drive(1'b1, SHL, '0, 1'b1, 1'b0);
      tick("nb_shl_after", 4'b0111, 1'b0, 1'b0);
      drive(1'b1, BURST, '0, 1'b0, 1'b0);
      tick("nb_op7_hold3", 4'b0111, 1'b0, 1'b0);
`endif

      n_tests++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain got %0d want 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
